// File: rtl/pipeline_if.sv
// Instruction fetch stage: issues word reads, realigns returned halfwords in a
// small FIFO and hands whole (16- or 32-bit) instructions to the decode stage.
module pipeline_if #(
   parameter logic [31:0] RESET_PC = 32'h80000000,
   parameter int          DEPTH_HW = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   input  logic        stall_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instruction_f_o,
   output logic        instr_valid_f_o,
   output logic [31:0] pc_f_o
);

   localparam int PW = $clog2(DEPTH_HW);
   localparam int CW = $clog2(DEPTH_HW + 1);
   localparam int SW = CW + 2;

   logic [PW-1:0]          rd_ptr_reg;
   logic [PW-1:0]          wr_ptr_reg;
   logic [PW-1:0]          rd_ptr_p1;
   logic [PW-1:0]          wr_ptr_p1;
   logic [CW-1:0]          count_reg;
   logic [CW-1:0]          count_next;
   logic [31:0]            fetch_pc_reg;
   logic [31:0]            head_pc_reg;
   logic [1:0]             out_cnt_reg;
   logic [1:0]             out_cnt_next;
   logic [1:0]             out_after_rsp;
   logic [1:0]             drop_cnt_reg;
   logic                   skip_low_reg;
   logic [DEPTH_HW*16-1:0] slots_flat;
   logic [15:0]            head_hw;
   logic [15:0]            next_hw;
   logic [15:0]            wr0_data;
   logic                   head_compressed;
   logic                   instr_ready;
   logic                   rsp_accept;
   logic                   wr1_en;
   logic                   pop;
   logic [1:0]             push_cnt;
   logic [1:0]             pop_cnt;
   logic [SW-1:0]          fill_need;
   logic                   unused_redirect_bit;

   assign unused_redirect_bit = redirect_pc_i[0];

   assign rd_ptr_p1 = rd_ptr_reg + PW'(1);
   assign wr_ptr_p1 = wr_ptr_reg + PW'(1);
   assign head_hw   = slots_flat[{rd_ptr_reg, 4'b0000} +: 16];
   assign next_hw   = slots_flat[{rd_ptr_p1, 4'b0000} +: 16];

   assign head_compressed = (head_hw[1:0] != 2'b11);
   assign instr_ready     = (count_reg >= CW'(2)) ||
                            ((count_reg == CW'(1)) && head_compressed);
   assign instr_valid_f_o = !reset && instr_ready;
   assign instruction_f_o = reset           ? 32'h0 :
                            head_compressed ? {16'h0, head_hw} :
                                              {next_hw, head_hw};
   assign pc_f_o          = head_pc_reg;

   // Reserve room for every in-flight word plus the one about to be requested.
   assign fill_need  = SW'(count_reg) + SW'({out_cnt_reg, 1'b0}) + SW'(2);
   assign imem_req_o = !reset && !redirect_i && (out_cnt_reg != 2'd2) &&
                       (fill_need <= SW'(DEPTH_HW));
   assign imem_addr_o = fetch_pc_reg;

   assign rsp_accept = imem_rvalid_i && !redirect_i && (drop_cnt_reg == 2'd0);
   assign wr1_en     = rsp_accept && !skip_low_reg;
   assign wr0_data   = skip_low_reg ? imem_rdata_i[31:16] : imem_rdata_i[15:0];
   assign push_cnt   = rsp_accept ? (skip_low_reg ? 2'd1 : 2'd2) : 2'd0;
   assign pop        = instr_valid_f_o && !stall_i && !redirect_i;
   assign pop_cnt    = pop ? (head_compressed ? 2'd1 : 2'd2) : 2'd0;
   assign count_next = count_reg + CW'(push_cnt) - CW'(pop_cnt);

   assign out_after_rsp = out_cnt_reg - {1'b0, imem_rvalid_i};

   always_comb begin
      out_cnt_next = out_cnt_reg;
      if (imem_req_o && !imem_rvalid_i) begin
         out_cnt_next = out_cnt_reg + 2'd1;
      end else if (!imem_req_o && imem_rvalid_i) begin
         out_cnt_next = out_cnt_reg - 2'd1;
      end
   end

   // One register per halfword slot; a response writes up to two consecutive slots.
   for (genvar gi = 0; gi < DEPTH_HW; gi++) begin : gen_slot
      logic [15:0] slot_reg;

      always_ff @(posedge clk) begin
         if (reset) begin
            slot_reg <= 16'h0;
         end else if (rsp_accept && (wr_ptr_reg == PW'(gi))) begin
            slot_reg <= wr0_data;
         end else if (wr1_en && (wr_ptr_p1 == PW'(gi))) begin
            slot_reg <= imem_rdata_i[31:16];
         end
      end

      assign slots_flat[gi*16 +: 16] = slot_reg;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         fetch_pc_reg <= {RESET_PC[31:2], 2'b00};
         head_pc_reg  <= {RESET_PC[31:1], 1'b0};
         out_cnt_reg  <= 2'd0;
         drop_cnt_reg <= 2'd0;
         skip_low_reg <= RESET_PC[1];
      end else if (redirect_i) begin
         // Every word still in flight after this cycle belongs to the old path.
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         fetch_pc_reg <= {redirect_pc_i[31:2], 2'b00};
         head_pc_reg  <= {redirect_pc_i[31:1], 1'b0};
         out_cnt_reg  <= out_after_rsp;
         drop_cnt_reg <= out_after_rsp;
         skip_low_reg <= redirect_pc_i[1];
      end else begin
         if (imem_req_o) begin
            fetch_pc_reg <= fetch_pc_reg + 32'd4;
         end
         out_cnt_reg <= out_cnt_next;
         if (imem_rvalid_i && (drop_cnt_reg != 2'd0)) begin
            drop_cnt_reg <= drop_cnt_reg - 2'd1;
         end
         if (rsp_accept) begin
            wr_ptr_reg   <= wr_ptr_reg + PW'(push_cnt);
            skip_low_reg <= 1'b0;
         end
         if (pop) begin
            rd_ptr_reg  <= rd_ptr_reg + PW'(pop_cnt);
            head_pc_reg <= head_pc_reg + (head_compressed ? 32'd2 : 32'd4);
         end
         count_reg <= count_next;
      end
   end

endmodule
